// File: rtl/exec_pkg.sv
// Shared types for the run/halt/single-step controller.
package exec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DRAIN,
    HALTED
  } exec_state_t;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_STOP = 2'd1;
  localparam logic [1:0] CAUSE_BRK  = 2'd2;
  localparam logic [1:0] CAUSE_HALT = 2'd3;

  // Cause codes are numerically ordered by priority, so max() resolves conflicts.
  function automatic logic [1:0] req_cause(input logic halt, input logic brk, input logic stop);
    if (halt)      return CAUSE_HALT;
    else if (brk)  return CAUSE_BRK;
    else if (stop) return CAUSE_STOP;
    else           return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Free-running unsigned counter that wraps modulo 2^W; cleared only by reset.
module wrap_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    count <= '0;
    else if (inc) count <= count + 1'b1;
  end

endmodule

// File: rtl/exec_controller.sv
// Run/halt/single-step control for the five-phase sequencer; stops land on an
// instruction boundary with the sequencer parked at IF.
module exec_controller
  import exec_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic             brk_hit,
  input  logic             halt_req,
  input  logic             phase_last,
  output logic             seq_enable,
  output logic             running,
  output logic             halted,
  output logic [1:0]       stop_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  exec_state_t state;
  logic        bnd;
  logic [1:0]  req;
  logic [1:0]  drain_cause;

  assign seq_enable = (state == RUN) || (state == STEP) || (state == DRAIN);
  assign running    = seq_enable;
  assign halted     = (state == HALTED);
  assign bnd        = seq_enable & phase_last;

  assign req         = req_cause(halt_req, brk_hit, stop);
  // A pending stop can only be promoted to a higher-priority cause, never demoted.
  assign drain_cause = (req > stop_cause) ? req : stop_cause;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      stop_cause <= CAUSE_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            stop_cause <= CAUSE_NONE;
          end else if (step) begin
            state      <= STEP;
            stop_cause <= CAUSE_NONE;
          end
        end
        RUN: begin
          if (req != CAUSE_NONE) begin
            stop_cause <= req;
            if (bnd) state <= (req == CAUSE_HALT) ? HALTED : IDLE;
            else     state <= DRAIN;
          end
        end
        DRAIN: begin
          stop_cause <= drain_cause;
          if (bnd) state <= (drain_cause == CAUSE_HALT) ? HALTED : IDLE;
        end
        STEP: begin
          // Only HALT is meaningful while stepping; stop/breakpoint are ignored.
          if (halt_req) stop_cause <= CAUSE_HALT;
          if (bnd) state <= (halt_req || stop_cause == CAUSE_HALT) ? HALTED : IDLE;
        end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  wrap_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (seq_enable),
    .count (cycle_count)
  );

  wrap_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bnd),
    .count (instr_count)
  );

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: table of stop-request vectors plus hand-written
// sequences for step, drain upgrade, HALTED, counter wrap and async reset.
module tb_exec_controller;

  logic clk, reset, start, step, stop, brk_hit, halt_req, phase_last;
  logic        seq_enable, running, halted;
  logic [1:0]  stop_cause;
  logic [31:0] cycle_count, instr_count;
  logic        seq_enable4, running4, halted4;
  logic [1:0]  stop_cause4;
  logic [3:0]  cycle_count4, instr_count4;

  int n_tests = 0;
  int n_fail  = 0;
  int phase;

  exec_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .stop(stop),
    .brk_hit(brk_hit), .halt_req(halt_req), .phase_last(phase_last),
    .seq_enable(seq_enable), .running(running), .halted(halted),
    .stop_cause(stop_cause), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  exec_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .step(step), .stop(stop),
    .brk_hit(brk_hit), .halt_req(halt_req), .phase_last(phase_last),
    .seq_enable(seq_enable4), .running(running4), .halted(halted4),
    .stop_cause(stop_cause4), .cycle_count(cycle_count4), .instr_count(instr_count4)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Environment model of the five-phase sequencer driven by seq_enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           phase <= 0;
    else if (seq_enable) phase <= (phase == 4) ? 0 : phase + 1;
  end
  assign phase_last = (phase == 4);

  typedef struct {
    logic [1:0]  cause;
    logic        halted;
    logic [31:0] instr;
    logic [31:0] cycle;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       brk, stp, hlt;
    int         at_phase;
    logic [1:0] cause;
    logic       halted;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; start = 0; step = 0; stop = 0; brk_hit = 0; halt_req = 0;
    @(negedge clk);
    reset = 0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_stopped(input string name);
    int n = 0;
    while (running && n < 50) begin tick(); n++; end
    if (running) chk({name, "_timeout"}, 32'(running), 32'd0);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({name, "_cause"},  32'(stop_cause), 32'(e.cause));
    chk({name, "_halted"}, 32'(halted),     32'(e.halted));
    chk({name, "_instr"},  instr_count,     e.instr);
    chk({name, "_cycle"},  cycle_count,     e.cycle);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // {brk, stop, halt, phase when asserted, cause, halted}; phase 4 coincides with bnd
    vecs[0] = '{0, 1, 0, 1, 2'd1, 0};
    vecs[1] = '{1, 0, 0, 2, 2'd2, 0};
    vecs[2] = '{1, 1, 0, 0, 2'd2, 0};
    vecs[3] = '{0, 0, 1, 3, 2'd3, 1};
    vecs[4] = '{1, 1, 1, 2, 2'd3, 1};
    vecs[5] = '{0, 1, 0, 4, 2'd1, 0};
    vecs[6] = '{0, 0, 1, 4, 2'd3, 1};
    vecs[7] = '{1, 0, 0, 4, 2'd2, 0};

    do_reset();
    chk("rst_seq_enable", 32'(seq_enable), 0);
    chk("rst_running",    32'(running), 0);
    chk("rst_halted",     32'(halted), 0);
    chk("rst_cause",      32'(stop_cause), 0);
    chk("rst_cycle",      cycle_count, 0);
    chk("rst_instr",      instr_count, 0);

    // Free-run, stop mid-instruction, drain to the 25th cycle's boundary
    pulse_start();
    chk("start_enable", 32'(seq_enable), 1);
    n = 0;
    while (cycle_count < 22 && n < 50) begin tick(); n++; end
    stop = 1; tick(); stop = 0;
    chk("drain_running", 32'(running), 1);
    chk("drain_cycle",   cycle_count, 23);
    sb.push_back('{2'd1, 1'b0, 32'd5, 32'd25});
    wait_stopped("run_stop");
    sb_check("run_stop");
    chk("run_stop_enable", 32'(seq_enable), 0);

    // Table: stop requests at various phases of the first instruction
    foreach (vecs[i]) begin
      do_reset();
      pulse_start();
      n = 0;
      while (phase != vecs[i].at_phase && n < 10) begin tick(); n++; end
      brk_hit = vecs[i].brk; stop = vecs[i].stp; halt_req = vecs[i].hlt;
      sb.push_back('{vecs[i].cause, vecs[i].halted, 32'd1, 32'd5});
      tick();
      brk_hit = 0; stop = 0; halt_req = 0;
      chk($sformatf("vec%0d_drain", i), 32'(running), (vecs[i].at_phase != 4) ? 32'd1 : 32'd0);
      wait_stopped($sformatf("vec%0d", i));
      sb_check($sformatf("vec%0d", i));
    end

    // Single step: exactly five enabled cycles, then repeat with ignored stop/brk
    do_reset();
    step = 1; tick(); step = 0;
    n = 0;
    while (seq_enable && n < 20) begin n++; tick(); end
    chk("step1_len", 32'(n), 5);
    sb.push_back('{2'd0, 1'b0, 32'd1, 32'd5});
    sb_check("step1");
    step = 1; tick(); step = 0;
    n = 0;
    while (seq_enable && n < 20) begin
      n++;
      stop = (n == 2); brk_hit = (n == 2);
      tick();
    end
    stop = 0; brk_hit = 0;
    chk("step2_len", 32'(n), 5);
    sb.push_back('{2'd0, 1'b0, 32'd2, 32'd10});
    sb_check("step2");

    // brk+stop together, then HALT upgrades the cause two cycles into DRAIN
    do_reset();
    pulse_start();
    tick();
    brk_hit = 1; stop = 1; tick(); brk_hit = 0; stop = 0;
    chk("upg_cause_brk", 32'(stop_cause), 2);
    chk("upg_in_drain",  32'(running), 1);
    tick();
    halt_req = 1; tick(); halt_req = 0;
    chk("upg_cause_halt", 32'(stop_cause), 3);
    sb.push_back('{2'd3, 1'b1, 32'd1, 32'd5});
    wait_stopped("upg");
    sb_check("upg");
    // HALTED ignores start and step
    pulse_start();
    step = 1; tick(); step = 0;
    tick();
    sb.push_back('{2'd3, 1'b1, 32'd1, 32'd5});
    sb_check("halted_hold");
    chk("halted_enable", 32'(seq_enable), 0);

    // Narrow counter wraps after 16 enabled cycles
    do_reset();
    pulse_start();
    for (int k = 0; k < 17; k++) tick();
    chk("wrap_cycle32", cycle_count, 17);
    chk("wrap_cycle4",  32'(cycle_count4), 1);
    chk("wrap_instr4",  32'(instr_count4), 3);

    // Async reset mid-run, checked before any further clock edge
    do_reset();
    pulse_start();
    for (int k = 0; k < 3; k++) tick();
    chk("pre_reset_cycle", cycle_count, 3);
    #2 reset = 1;
    #1;
    chk("async_enable",  32'(seq_enable), 0);
    chk("async_running", 32'(running), 0);
    chk("async_halted",  32'(halted), 0);
    chk("async_cause",   32'(stop_cause), 0);
    chk("async_cycle",   cycle_count, 0);
    chk("async_instr",   instr_count, 0);
    @(negedge clk);
    reset = 0;
    tick();
    chk("post_reset_idle", 32'(running), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
